// File: rtl/mos6502_decoder_wb_sweeper_pkg.sv
// Shared types and helpers for the 6502 decoder Wishbone sweeper.
// MOS6502_SWEEP_SINGLE_STEP_EN adds the PAUSE state used by single-step mode.
package mos6502_decoder_wb_sweeper_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WR_INSTR,
    ST_RD_LOW,
    ST_RD_MID,
    ST_RD_HI,
    ST_GAP,
    ST_NEXT,
    ST_DONE,
    ST_ERROR
`ifdef MOS6502_SWEEP_SINGLE_STEP_EN
    , ST_PAUSE
`endif
  } state_t;

  localparam logic [31:0] INSTR_OFF = 32'h0;
  localparam logic [31:0] LOW_OFF   = 32'h4;
  localparam logic [31:0] MID_OFF   = 32'h8;
  localparam logic [31:0] HI_OFF    = 32'hC;
  localparam int          DECODE_W  = 66;

  function automatic logic [31:0] sig_next(input logic [31:0] sig, input logic [31:0] w);
    return {sig[30:0], sig[31]} ^ w;
  endfunction

  function automatic logic [31:0] reg_offset(input state_t kind);
    case (kind)
      ST_RD_LOW: return LOW_OFF;
      ST_RD_MID: return MID_OFF;
      ST_RD_HI:  return HI_OFF;
      default:   return INSTR_OFF;
    endcase
  endfunction

  // Transfer that follows a completed one within a single opcode.
  function automatic state_t next_xfer(input state_t kind);
    case (kind)
      ST_WR_INSTR: return ST_RD_LOW;
      ST_RD_LOW:   return ST_RD_MID;
      ST_RD_MID:   return ST_RD_HI;
      default:     return ST_NEXT;
    endcase
  endfunction

endpackage

// File: rtl/mos6502_decoder_wb_sweeper_if.sv
// Wishbone initiator/target bundle between the sweeper and the decoder register block.
interface mos6502_decoder_wb_sweeper_if;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [3:0]  sel;
  logic [31:0] adr;
  logic [31:0] dat_w;
  logic [31:0] dat_r;
  logic        ack;

  modport master (output cyc, stb, we, sel, adr, dat_w, input dat_r, ack);
  modport slave  (input cyc, stb, we, sel, adr, dat_w, output dat_r, ack);
endinterface

// File: rtl/mos6502_decoder_wb_sweeper_wb_master_xfer.sv
// Single Wishbone transfer engine: ack timeout, one idle cycle after every ack, read capture.
module wb_master_xfer #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        go,
  input  logic        go_we,
  input  logic [31:0] go_adr,
  input  logic [31:0] go_dat,
  mos6502_decoder_wb_sweeper_if.master bus,
  output logic        idle,
  output logic        ack_hit,
  output logic        timeout,
  output logic [31:0] rdata
);

  typedef enum logic [1:0] {X_IDLE, X_BUS, X_GAP} xstate_t;

  localparam int                CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  xstate_t          xstate_reg;
  logic             active_reg;
  logic             we_reg;
  logic [3:0]       sel_reg;
  logic [31:0]      adr_reg;
  logic [31:0]      dat_reg;
  logic [31:0]      rdata_reg;
  logic [CNT_W-1:0] cnt_reg;

  assign bus.cyc   = active_reg;
  assign bus.stb   = active_reg;
  assign bus.we    = we_reg;
  assign bus.sel   = sel_reg;
  assign bus.adr   = adr_reg;
  assign bus.dat_w = dat_reg;

  assign idle    = (xstate_reg == X_IDLE);
  assign ack_hit = (xstate_reg == X_BUS) && bus.ack;
  assign timeout = (xstate_reg == X_BUS) && !bus.ack && (cnt_reg == CNT_LAST);
  assign rdata   = rdata_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xstate_reg <= X_IDLE;
      active_reg <= 1'b0;
      we_reg     <= 1'b0;
      sel_reg    <= 4'h0;
      adr_reg    <= 32'h0;
      dat_reg    <= 32'h0;
      rdata_reg  <= 32'h0;
      cnt_reg    <= '0;
    end else begin
      case (xstate_reg)
        // The gap cycle may launch the next transfer, so exactly one idle cycle separates them.
        X_IDLE, X_GAP: begin
          if (go) begin
            active_reg <= 1'b1;
            we_reg     <= go_we;
            sel_reg    <= 4'hF;
            adr_reg    <= go_adr;
            dat_reg    <= go_dat;
            cnt_reg    <= '0;
            xstate_reg <= X_BUS;
          end else begin
            xstate_reg <= X_IDLE;
          end
        end
        X_BUS: begin
          if (bus.ack) begin
            active_reg <= 1'b0;
            we_reg     <= 1'b0;
            sel_reg    <= 4'h0;
            if (!we_reg) rdata_reg <= bus.dat_r;
            xstate_reg <= X_GAP;
          end else if (cnt_reg == CNT_LAST) begin
            active_reg <= 1'b0;
            we_reg     <= 1'b0;
            sel_reg    <= 4'h0;
            xstate_reg <= X_IDLE;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        default: xstate_reg <= X_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/mos6502_decoder_wb_sweeper.sv
// Sweeps an opcode range through the decoder register block and signs the 66-bit decodes.
// MOS6502_SWEEP_SINGLE_STEP_EN adds step_i and a PAUSE between opcodes.
module mos6502_decoder_wb_sweeper
  import mos6502_decoder_wb_sweeper_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR      = 32'h3000_0000,
  parameter int          TIMEOUT_CYCLES = 16
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic                start_i,
  input  logic [7:0]          op_first_i,
  input  logic [7:0]          op_last_i,
`ifdef MOS6502_SWEEP_SINGLE_STEP_EN
  input  logic                step_i,
`endif
  output logic                busy_o,
  output logic                done_o,
  output logic                error_o,
  output logic [7:0]          cur_opcode_o,
  output logic [DECODE_W-1:0] last_decoded_o,
  output logic                result_valid_o,
  output logic [31:0]         signature_o,
  output logic [8:0]          nonzero_count_o,
  mos6502_decoder_wb_sweeper_if.master wbm
);

  state_t              state_reg;
  state_t              gap_from_reg;
  logic [7:0]          last_reg;
  logic [7:0]          cur_opcode_reg;
  logic                busy_reg;
  logic                done_reg;
  logic                error_reg;
  logic                result_valid_reg;
  logic [DECODE_W-1:0] last_decoded_reg;
  logic [31:0]         sig_reg;
  logic [8:0]          nonzero_reg;
  logic [31:0]         low_reg;
  logic [31:0]         mid_reg;

  logic                go;
  state_t              go_kind;
  logic [7:0]          go_op;
  logic                xfer_idle;
  logic                ack_hit;
  logic                timeout;
  logic [31:0]         rdata;
  logic [DECODE_W-1:0] decode_now;

  assign decode_now = {rdata[1:0], mid_reg, low_reg};

  // Launch requests: fresh transfer from an idle engine, or chained from the gap/NEXT cycle.
  always_comb begin
    go      = 1'b0;
    go_kind = ST_WR_INSTR;
    go_op   = cur_opcode_reg;
    case (state_reg)
      ST_WR_INSTR, ST_RD_LOW, ST_RD_MID, ST_RD_HI: begin
        go      = xfer_idle;
        go_kind = state_reg;
      end
      ST_GAP: begin
        go      = 1'b1;
        go_kind = next_xfer(gap_from_reg);
      end
`ifndef MOS6502_SWEEP_SINGLE_STEP_EN
      ST_NEXT: begin
        go      = (cur_opcode_reg != last_reg);
        go_kind = ST_WR_INSTR;
        go_op   = cur_opcode_reg + 8'd1;
      end
`endif
      default: ;
    endcase
  end

  wb_master_xfer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_xfer (
    .clk     (wb_clk_i),
    .rst_n   (wb_rst_i),
    .go      (go),
    .go_we   (go_kind == ST_WR_INSTR),
    .go_adr  (BASE_ADDR + reg_offset(go_kind)),
    .go_dat  ({24'h0, go_op}),
    .bus     (wbm),
    .idle    (xfer_idle),
    .ack_hit (ack_hit),
    .timeout (timeout),
    .rdata   (rdata)
  );

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      state_reg        <= ST_IDLE;
      gap_from_reg     <= ST_IDLE;
      last_reg         <= 8'h0;
      cur_opcode_reg   <= 8'h0;
      busy_reg         <= 1'b0;
      done_reg         <= 1'b0;
      error_reg        <= 1'b0;
      result_valid_reg <= 1'b0;
      last_decoded_reg <= '0;
      sig_reg          <= 32'h0;
      nonzero_reg      <= 9'h0;
      low_reg          <= 32'h0;
      mid_reg          <= 32'h0;
    end else begin
      done_reg         <= 1'b0;
      result_valid_reg <= 1'b0;
      case (state_reg)
        ST_IDLE, ST_ERROR: begin
          if (start_i) begin
            last_reg       <= op_last_i;
            cur_opcode_reg <= op_first_i;
            sig_reg        <= 32'h0;
            nonzero_reg    <= 9'h0;
            error_reg      <= 1'b0;
            busy_reg       <= 1'b1;
            state_reg      <= ST_WR_INSTR;
          end
        end
        ST_WR_INSTR, ST_RD_LOW, ST_RD_MID, ST_RD_HI: begin
          if (ack_hit) begin
            gap_from_reg <= state_reg;
            state_reg    <= (state_reg == ST_RD_HI) ? ST_NEXT : ST_GAP;
          end else if (timeout) begin
            error_reg <= 1'b1;
            busy_reg  <= 1'b0;
            state_reg <= ST_ERROR;
          end
        end
        ST_GAP: begin
          if (gap_from_reg == ST_RD_LOW) begin
            low_reg <= rdata;
            sig_reg <= sig_next(sig_reg, rdata);
          end else if (gap_from_reg == ST_RD_MID) begin
            mid_reg <= rdata;
            sig_reg <= sig_next(sig_reg, rdata);
          end
          state_reg <= next_xfer(gap_from_reg);
        end
        ST_NEXT: begin
          sig_reg          <= sig_next(sig_reg, {30'h0, rdata[1:0]});
          last_decoded_reg <= decode_now;
          result_valid_reg <= 1'b1;
          if (decode_now != '0) nonzero_reg <= nonzero_reg + 9'd1;
          if (cur_opcode_reg == last_reg) begin
            done_reg  <= 1'b1;
            busy_reg  <= 1'b0;
            state_reg <= ST_DONE;
          end else begin
            cur_opcode_reg <= cur_opcode_reg + 8'd1;
`ifdef MOS6502_SWEEP_SINGLE_STEP_EN
            state_reg      <= ST_PAUSE;
`else
            state_reg      <= ST_WR_INSTR;
`endif
          end
        end
`ifdef MOS6502_SWEEP_SINGLE_STEP_EN
        ST_PAUSE: begin
          if (step_i) state_reg <= ST_WR_INSTR;
        end
`endif
        ST_DONE: state_reg <= ST_IDLE;
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign busy_o          = busy_reg;
  assign done_o          = done_reg;
  assign error_o         = error_reg;
  assign cur_opcode_o    = cur_opcode_reg;
  assign last_decoded_o  = last_decoded_reg;
  assign result_valid_o  = result_valid_reg;
  assign signature_o     = sig_reg;
  assign nonzero_count_o = nonzero_reg;

endmodule

// File: doc/mos6502_decoder_wb_sweeper.md
Name: mos6502_decoder_wb_sweeper

Overview:
Wishbone initiator that exercises the memory-mapped 6502 instruction-decoder register block from the host side. For each opcode in a programmed range it writes the instruction register, reads back the three decoder-output words, assembles the 66-bit decode and folds it into a running signature. It sits between an on-chip self-test controller and the decoder's Wishbone slave port, so decoder silicon can be checked with a single start pulse.

Parameters:
BASE_ADDR, 32'h3000_0000, address of instruction register; decoder low/mid/hi words at +4/+8/+C
TIMEOUT_CYCLES, 16, max cycles waiting for wbm_ack_i per transfer before abort (>=2)

Ports:
wb_clk_i  in  1  clock
wb_rst_i  in  1  reset, asynchronous, active-low
start_i  in  1  single-cycle pulse; begins a sweep (ignored while busy)
op_first_i  in  8  first opcode of sweep, sampled on start_i
op_last_i  in  8  last opcode of sweep, sampled on start_i
busy_o  out  1  sweep in progress
done_o  out  1  one-cycle pulse when sweep completes without error
error_o  out  1  sticky; ack timeout occurred
cur_opcode_o  out  8  opcode currently being processed
last_decoded_o  out  66  {hi[1:0],mid,low} of most recent opcode
result_valid_o  out  1  one-cycle pulse when last_decoded_o updates
signature_o  out  32  running signature
nonzero_count_o  out  9  number of opcodes whose 66-bit decode is non-zero
wbm_cyc_o  out  1  Wishbone cycle
wbm_stb_o  out  1  Wishbone strobe
wbm_we_o  out  1  write enable
wbm_sel_o  out  4  byte selects, always 4'hF during transfer
wbm_adr_o  out  32  address
wbm_dat_o  out  32  write data
wbm_dat_i  in  32  read data
wbm_ack_i  in  1  acknowledge

Behaviour:
- Reset (wb_rst_i low, asynchronous): all outputs 0, FSM to IDLE, signature 0, counts 0.
- States: IDLE, WR_INSTR, RD_LOW, RD_MID, RD_HI, GAP, NEXT, DONE, ERROR.
- IDLE: on start_i, latch first/last and set cur_opcode=first. Clear signature, nonzero_count and error_o. Set busy_o. Go WR_INSTR.
- Transfer states: cyc=stb=1, sel=F, held stable until wbm_ack_i.
  - WR_INSTR: we=1, adr=BASE_ADDR, dat={24'h0,cur_opcode}.
  - RD_LOW/RD_MID/RD_HI: we=0, adr=BASE+4/+8/+C. Capture wbm_dat_i in the ack cycle.
- After every ack: the following cycle has cyc=stb=0 (GAP, exactly one idle cycle). This is required because the slave's ack is registered and must not alias into the next transfer. Then continue with the next transfer state.
- Signature update per read word w, in order low, mid, hi: sig <= {sig[30:0],sig[31]} ^ w. For the hi word, only bits [1:0] are used; upper bits are masked to 0.
- After RD_HI ack, in NEXT:
  - last_decoded_o updated; result_valid_o pulses.
  - nonzero_count increments if the decode is non-zero.
  - If cur_opcode==last, go DONE. Otherwise increment cur_opcode and go WR_INSTR.
- Wrap: if first>last, sweep wraps 0xFF->0x00 and stops at last. first==last gives exactly one opcode (4 transfers). A full 256-opcode sweep gives a count of up to 256 (9 bits).
- DONE: done_o pulses one cycle, busy_o drops, return to IDLE. Outputs hold.
- Timeout: counter resets at each transfer start. If no ack after TIMEOUT_CYCLES cycles with stb high:
  - drop cyc/stb next cycle, set error_o, go ERROR.
  - ERROR: busy_o=0, no done_o, stays until next start_i (restarts a sweep).
- start_i while busy: ignored. Ack while cyc=0: ignored.
- Reset mid-transfer: cyc/stb drop immediately (asynchronous).

Optional Feature:
MOS6502_SWEEP_SINGLE_STEP_EN
- Defined: adds input step_i (1 bit). After NEXT (when not last), the FSM enters state PAUSE with cyc=0 and busy_o=1. It stays there until a step_i pulse, then goes WR_INSTR.
- Undefined: no step_i port, no PAUSE state; the sweep runs freely.

Decomposition:
- Shared package holds:
  - state encoding enum
  - register offset constants INSTR_OFF=0, LOW_OFF=4, MID_OFF=8, HI_OFF=C
  - DECODE_W=66
  - signature update function
- One natural sub-module: wb_master_xfer. It performs a single Wishbone transfer with timeout, the post-ack GAP cycle, and captured read data. The sweeper FSM sequences it.

Test Plan:
- first=last=8'hA9, slave model returns low=32'h2000_0000, mid=32'h1000_0000, hi=0:
  - exactly 4 transfers: W 0x30000000 dat 0x000000A9 sel F, then R 0x30000004, 0x30000008, 0x3000000C
  - last_decoded=66'h0_1000_0000_2000_0000, nonzero_count=1, one done_o pulse
- Full sweep 00..FF against a slave returning low=op, mid=~op, hi=op:
  - signature_o matches the golden model
  - nonzero_count=256
  - 1024 transfers, each followed by one idle cycle
- Slave never acks, TIMEOUT_CYCLES=16:
  - stb high for 16 cycles, then cyc=0, error_o=1, no done_o
  - next start_i clears error_o and restarts
- first=FE, last=01: opcodes FE,FF,00,01 processed in order, then done.
- wb_rst_i asserted during RD_MID: cyc/stb/busy_o drop immediately, all outputs 0; a new start after release runs cleanly.
- start_i pulsed mid-sweep: no effect on cur_opcode sequence or signature.
